// File: rtl/mem_pkg.sv
// Shared types and derived-geometry helpers for the cache main-memory models.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE
   } mem_state_e;

   localparam int unsigned LINE_W = 256;

   typedef logic [LINE_W-1:0] line_t;

   // Words per cache line.
   function automatic int unsigned calc_wpl(input int unsigned line_w, input int unsigned data_w);
      return line_w / data_w;
   endfunction

   // Byte-offset bits inside one word.
   function automatic int unsigned calc_boff(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/mem_latency_ctr.sv
// Loadable down-counter with a registered zero flag, used to pace memory accesses.
module mem_latency_ctr
   import mem_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             zero_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   // Zero flag tracks the next count so it is valid the cycle after a load.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         zero_q <= (cnt_d == '0);
      end
   end

   assign zero_o = zero_q;

endmodule

// File: rtl/cache_main_mem.sv
// Main-memory model serving line refills and write-backs with programmable latency
// and busy/done handshakes.
module cache_main_mem
   import mem_pkg::*;
#(
   parameter int unsigned MEM_DEPTH        = 12,
   parameter int unsigned DATA_WIDTH       = 64,
   parameter int unsigned ADDR_WIDTH       = 64,
   parameter int unsigned CACHE_LINE_WIDTH = 256,
   parameter int unsigned LATENCY          = 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [ADDR_WIDTH-1:0]       i_mem_read_address,
   input  logic                        i_mem_read_req,
   output logic                        o_mem_read_done,
   output logic [CACHE_LINE_WIDTH-1:0] o_cache_line,
   input  logic [ADDR_WIDTH-1:0]       i_mem_write_address,
   input  logic                        i_mem_write_req,
   input  logic [CACHE_LINE_WIDTH-1:0] i_mem_write_line,
   output logic                        o_mem_write_done,
   output logic                        o_mem_busy
);

   localparam int unsigned WPL   = calc_wpl(CACHE_LINE_WIDTH, DATA_WIDTH);
   localparam int unsigned BOFF  = calc_boff(DATA_WIDTH);
   localparam int unsigned WORDS = 1 << MEM_DEPTH;
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [MEM_DEPTH-1:0] ALIGN_MASK = ~MEM_DEPTH'(WPL - 1);

   mem_state_e                  state_q, state_d;
   logic [MEM_DEPTH-1:0]        base_q, base_d;
   logic [CACHE_LINE_WIDTH-1:0] wline_q, wline_d;
   logic [CACHE_LINE_WIDTH-1:0] line_q;
   logic                        rd_done_q, rd_done_d;
   logic                        wr_done_q, wr_done_d;
   logic                        busy_q;
   logic                        do_read, do_write;
   logic                        ctr_load, ctr_dec, ctr_zero;
   logic [MEM_DEPTH-1:0]        rd_idx, wr_idx;
   logic                        unused_addr_bits;

   logic [DATA_WIDTH-1:0]       mem_q [WORDS];

   // Line-aligned word index; byte offset and high address bits are ignored.
   assign rd_idx = i_mem_read_address[BOFF +: MEM_DEPTH] & ALIGN_MASK;
   assign wr_idx = i_mem_write_address[BOFF +: MEM_DEPTH] & ALIGN_MASK;

   assign unused_addr_bits = ^{i_mem_read_address[ADDR_WIDTH-1:BOFF+MEM_DEPTH],
                               i_mem_read_address[BOFF-1:0],
                               i_mem_write_address[ADDR_WIDTH-1:BOFF+MEM_DEPTH],
                               i_mem_write_address[BOFF-1:0]};

   mem_latency_ctr #(
      .WIDTH (CNT_W)
   ) u_ctr (
      .clk_i      (i_clk),
      .rst_ni     (i_rst_n),
      .load_i     (ctr_load),
      .load_val_i (CNT_W'(LATENCY - 1)),
      .dec_i      (ctr_dec),
      .zero_o     (ctr_zero)
   );

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      wline_d   = wline_q;
      rd_done_d = 1'b0;
      wr_done_d = 1'b0;
      do_read   = 1'b0;
      do_write  = 1'b0;
      ctr_load  = 1'b0;
      ctr_dec   = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Write-back takes priority so a dirty victim leaves before its refill.
            if (i_mem_write_req) begin
               base_d   = wr_idx;
               wline_d  = i_mem_write_line;
               ctr_load = 1'b1;
               state_d  = WRITE;
            end else if (i_mem_read_req) begin
               base_d   = rd_idx;
               ctr_load = 1'b1;
               state_d  = READ;
            end
         end
         READ: begin
            if (ctr_zero) begin
               do_read   = 1'b1;
               rd_done_d = 1'b1;
               state_d   = IDLE;
            end else begin
               ctr_dec = 1'b1;
            end
         end
         WRITE: begin
            if (ctr_zero) begin
               do_write  = 1'b1;
               wr_done_d = 1'b1;
               state_d   = IDLE;
            end else begin
               ctr_dec = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         base_q    <= '0;
         wline_q   <= '0;
         rd_done_q <= 1'b0;
         wr_done_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         wline_q   <= wline_d;
         rd_done_q <= rd_done_d;
         wr_done_q <= wr_done_d;
         busy_q    <= (state_d != IDLE);
      end
   end

   // Read line is captured from the array at the completing edge and held until the next read.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         line_q <= '0;
      end else if (do_read) begin
         for (int i = 0; i < WPL; i++) begin
            line_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem_q[base_q + MEM_DEPTH'(i)];
         end
      end
   end

   // Whole line committed at once; indices wrap at the top of the array.
   always_ff @(posedge i_clk) begin
      if (do_write) begin
         for (int i = 0; i < WPL; i++) begin
            mem_q[base_q + MEM_DEPTH'(i)] <= wline_q[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign o_mem_read_done  = rd_done_q;
   assign o_mem_write_done = wr_done_q;
   assign o_mem_busy       = busy_q;
   assign o_cache_line     = line_q;

endmodule

// File: tb/tb_cache_main_mem.sv
// Self-checking bench: two memory instances (LATENCY 1 and 4) against an array-based model.
module tb_cache_main_mem;
   import mem_pkg::*;

   localparam int unsigned NW = 4096;

   logic             clk;
   logic             rst_n;
   logic [1:0][63:0] rd_addr, wr_addr;
   logic [1:0]       rd_req, wr_req, rd_done, wr_done, busy;
   logic [1:0][255:0] wr_line, line_o;

   logic [63:0] mdl [2][NW];
   line_t       last_line [2];
   int          vectors;
   int          errors;

   cache_main_mem #(.LATENCY(1)) u_l1 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_mem_read_address(rd_addr[0]), .i_mem_read_req(rd_req[0]),
      .o_mem_read_done(rd_done[0]), .o_cache_line(line_o[0]),
      .i_mem_write_address(wr_addr[0]), .i_mem_write_req(wr_req[0]),
      .i_mem_write_line(wr_line[0]), .o_mem_write_done(wr_done[0]),
      .o_mem_busy(busy[0])
   );

   cache_main_mem #(.LATENCY(4)) u_l4 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_mem_read_address(rd_addr[1]), .i_mem_read_req(rd_req[1]),
      .o_mem_read_done(rd_done[1]), .o_cache_line(line_o[1]),
      .i_mem_write_address(wr_addr[1]), .i_mem_write_req(wr_req[1]),
      .i_mem_write_line(wr_line[1]), .o_mem_write_done(wr_done[1]),
      .o_mem_busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Done is seen at the (LATENCY+1)-th falling edge after the request is raised.
   function automatic int exp_lat(input int d);
      return (d == 0) ? 2 : 5;
   endfunction

   function automatic int unsigned base_of(input logic [63:0] a);
      int unsigned w;
      w = int'((a >> 3) % 64'd4096);
      return (w / 4) * 4;
   endfunction

   function automatic line_t exp_line(input int d, input logic [63:0] a);
      line_t l;
      int unsigned b;
      b = base_of(a);
      for (int i = 0; i < 4; i++) l[i*64 +: 64] = mdl[d][(b + i) % NW];
      return l;
   endfunction

   function automatic line_t rand_line();
      line_t l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic model_write(input int d, input logic [63:0] a, input line_t l);
      int unsigned b;
      b = base_of(a);
      for (int i = 0; i < 4; i++) mdl[d][(b + i) % NW] = l[i*64 +: 64];
   endtask

   // One request; returns the falling-edge count at done (-1 on timeout) and the line output.
   task automatic issue(input int d, input bit wr, input logic [63:0] a, input line_t wl,
                        output line_t rl, output int lat);
      @(negedge clk);
      if (wr) begin
         wr_req[d] = 1'b1; wr_addr[d] = a; wr_line[d] = wl;
      end else begin
         rd_req[d] = 1'b1; rd_addr[d] = a;
      end
      lat = -1;
      for (int n = 1; n <= 64; n++) begin
         @(negedge clk);
         if (wr && n == 1) wr_line[d] = rand_line();
         if (wr ? wr_done[d] : rd_done[d]) begin
            lat = n;
            break;
         end
      end
      if (wr) wr_req[d] = 1'b0; else rd_req[d] = 1'b0;
      rl = line_o[d];
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rd_req = '0; wr_req = '0; rd_addr = '0; wr_addr = '0; wr_line = '0;
      #12;
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (busy[d] !== 1'b0 || rd_done[d] !== 1'b0 || wr_done[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags[%0d]: busy=%b rd_done=%b wr_done=%b want 0 0 0",
                     d, busy[d], rd_done[d], wr_done[d]);
         end
         vectors++;
         if (line_o[d] !== '0) begin
            errors++;
            $display("FAIL reset_line[%0d]: got %h want 0", d, line_o[d]);
         end
         last_line[d] = '0;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic preload();
      line_t l, rl;
      int    lat, bad;
      for (int d = 0; d < 2; d++) begin
         bad = 0;
         for (int i = 0; i < NW; i++) mdl[d][i] = 64'(i);
         for (int ln = 0; ln < NW / 4; ln++) begin
            for (int i = 0; i < 4; i++) l[i*64 +: 64] = 64'(ln * 4 + i);
            issue(d, 1'b1, 64'(ln * 32), l, rl, lat);
            if (lat != exp_lat(d)) bad++;
         end
         vectors++;
         if (bad != 0) begin
            errors++;
            $display("FAIL preload[%0d]: %0d writes with wrong latency, want 0", d, bad);
         end
      end
   endtask

   task automatic test_basic_read();
      line_t rl, want;
      int    lat;
      logic [63:0] addrs [3];
      addrs[0] = 64'h20; addrs[1] = 64'h28; addrs[2] = 64'h7FE0;
      for (int k = 0; k < 3; k++) begin
         want = (k < 2) ? {64'd7, 64'd6, 64'd5, 64'd4}
                        : {64'd4095, 64'd4094, 64'd4093, 64'd4092};
         issue(0, 1'b0, addrs[k], '0, rl, lat);
         vectors++;
         if (lat !== 2) begin
            errors++;
            $display("FAIL basic_lat addr=%h: got %0d want 2", addrs[k], lat);
         end
         vectors++;
         if (rl !== want) begin
            errors++;
            $display("FAIL basic_line addr=%h: got %h want %h", addrs[k], rl, want);
         end
         last_line[0] = rl;
      end
   endtask

   task automatic test_latency_write_read();
      line_t rl, want;
      int    lat;
      want = {64'hD, 64'hC, 64'hB, 64'hA};
      issue(1, 1'b1, 64'h40, want, rl, lat);
      model_write(1, 64'h40, want);
      vectors++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL lat4_write: got %0d want 5", lat);
      end
      issue(1, 1'b0, 64'h40, '0, rl, lat);
      vectors++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL lat4_read: got %0d want 5", lat);
      end
      vectors++;
      if (rl !== want) begin
         errors++;
         $display("FAIL lat4_line: got %h want %h", rl, want);
      end
      last_line[1] = rl;
   endtask

   task automatic test_collision();
      line_t wl, got, rl;
      int    wr_n, rd_n, busy_err, lat;
      wl = rand_line();
      got = '0; wr_n = -1; rd_n = -1; busy_err = 0;
      @(negedge clk);
      wr_req[1] = 1'b1; wr_addr[1] = 64'h60; wr_line[1] = wl;
      rd_req[1] = 1'b1; rd_addr[1] = 64'h0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n <= 10 && busy[1] !== ((n != 5) && (n != 10))) busy_err++;
         if (wr_done[1]) begin
            if (wr_n < 0) wr_n = n;
            wr_req[1] = 1'b0;
         end
         if (rd_done[1]) begin
            if (rd_n < 0) rd_n = n;
            rd_req[1] = 1'b0;
            got = line_o[1];
         end
      end
      wr_req[1] = 1'b0; rd_req[1] = 1'b0;
      model_write(1, 64'h60, wl);
      vectors++;
      if (wr_n !== 5 || rd_n !== 10) begin
         errors++;
         $display("FAIL collide_order: wr_done@%0d rd_done@%0d want 5 and 10", wr_n, rd_n);
      end
      vectors++;
      if (busy_err !== 0) begin
         errors++;
         $display("FAIL collide_busy: %0d bad busy cycles want 0", busy_err);
      end
      vectors++;
      if (got !== {64'd3, 64'd2, 64'd1, 64'd0}) begin
         errors++;
         $display("FAIL collide_line: got %h want 0000..03_02_01_00", got);
      end
      issue(1, 1'b0, 64'h60, '0, rl, lat);
      vectors++;
      if (rl !== wl) begin
         errors++;
         $display("FAIL collide_wb: got %h want %h", rl, wl);
      end
      last_line[1] = rl;
   endtask

   task automatic test_drop();
      logic [63:0] a;
      int          pulses, first, busy_err;
      line_t       got;
      a = {$urandom, $urandom};
      pulses = 0; first = -1; busy_err = 0; got = '0;
      @(negedge clk);
      rd_req[1] = 1'b1; rd_addr[1] = a;
      @(negedge clk);
      rd_req[1] = 1'b0;
      for (int n = 2; n <= 14; n++) begin
         @(negedge clk);
         if (rd_done[1]) begin
            pulses++;
            if (first < 0) begin first = n; got = line_o[1]; end
         end
         if (first >= 0 && busy[1] !== 1'b0) busy_err++;
      end
      vectors++;
      if (pulses !== 1 || first !== 5) begin
         errors++;
         $display("FAIL drop_done: %0d pulses first@%0d want 1 at 5", pulses, first);
      end
      vectors++;
      if (busy_err !== 0) begin
         errors++;
         $display("FAIL drop_busy: %0d busy cycles after done want 0", busy_err);
      end
      vectors++;
      if (got !== exp_line(1, a)) begin
         errors++;
         $display("FAIL drop_line: got %h want %h", got, exp_line(1, a));
      end
      last_line[1] = got;
   endtask

   task automatic test_reset_midwrite();
      line_t rl;
      int    lat;
      bit    saw;
      saw = 1'b0;
      @(negedge clk);
      wr_req[1] = 1'b1; wr_addr[1] = 64'h80; wr_line[1] = rand_line();
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1;
      if (wr_done[1]) saw = 1'b1;
      rst_n = 1'b0;
      wr_req[1] = 1'b0;
      #1;
      vectors++;
      if (busy[1] !== 1'b0 || wr_done[1] !== 1'b0 || rd_done[1] !== 1'b0 || line_o[1] !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: busy=%b wr_done=%b rd_done=%b line=%h want all 0",
                  busy[1], wr_done[1], rd_done[1], line_o[1]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      last_line[0] = '0; last_line[1] = '0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (wr_done[1]) saw = 1'b1;
      end
      vectors++;
      if (saw !== 1'b0) begin
         errors++;
         $display("FAIL midreset_done: got a write done pulse want none");
      end
      issue(1, 1'b0, 64'h80, '0, rl, lat);
      vectors++;
      if (rl !== {64'd19, 64'd18, 64'd17, 64'd16}) begin
         errors++;
         $display("FAIL midreset_mem: got %h want words 19..16", rl);
      end
      last_line[1] = rl;
   endtask

   task automatic test_random();
      int          d, lat;
      bit          wr;
      logic [63:0] a;
      line_t       wl, rl;
      for (int k = 0; k < 60; k++) begin
         d  = int'($urandom_range(1, 0));
         wr = 1'($urandom_range(1, 0));
         a  = {$urandom, $urandom};
         wl = rand_line();
         issue(d, wr, a, wl, rl, lat);
         vectors++;
         if (lat !== exp_lat(d)) begin
            errors++;
            $display("FAIL rand_lat[%0d] inst=%0d wr=%0d: got %0d want %0d", k, d, wr, lat, exp_lat(d));
         end
         vectors++;
         if (wr) begin
            model_write(d, a, wl);
            if (rl !== last_line[d]) begin
               errors++;
               $display("FAIL rand_hold[%0d] inst=%0d: got %h want %h", k, d, rl, last_line[d]);
            end
         end else begin
            if (rl !== exp_line(d, a)) begin
               errors++;
               $display("FAIL rand_read[%0d] inst=%0d addr=%h: got %h want %h", k, d, a, rl, exp_line(d, a));
            end
            last_line[d] = exp_line(d, a);
         end
      end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      test_reset();
      preload();
      test_basic_read();
      test_latency_write_read();
      test_collision();
      test_drop();
      test_reset_midwrite();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
